wb_stage_ext: RTL

Parametrised write-back stage for the RV32/RV64 pipeline: sits after MA and selects, aligns and sign/zero-extends load data or passes the ALU result to the register file (ID). Adds three things:
- XLEN-generic load alignment, including ld/lwu for XLEN=64.
- A two-beat assembler for misaligned loads that cross an XLEN/8 boundary.
- A FWD_DEPTH-deep write-back history for EX/ID forwarding, which generalises the single wbk_data_wb2 register.

---
 rtl/wb_stage_ext.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_stage_ext.sv
// ---------------------------------------------------------------------------
// wb_stage_ext
//   Write-back stage of the RV32/RV64 pipeline. Selects the ALU result or the
//   aligned and extended load data for the register file. A two-beat
//   assembler handles loads that straddle an XLEN/8 boundary. A FWD_DEPTH-deep
//   history of write-back results feeds EX/ID forwarding.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   cmd_ld_wb     instruction in WB is a load
//   ld_code_wb    funct3 of the load
//   rd_data_wb    ALU result; the effective address for loads
//   ld_data_wb    XLEN-aligned memory read beat
//   ld_vld_wb     ld_data_wb valid this cycle
//   ld_split_wb   load spans two beats (qualified with the first beat)
//   wbk_en_wb     instruction writes rd
//   rd_adr_wb     destination register
//   stall         pipeline stall
//   rst_pipe      pipeline flush
//   wbk_data_wb   write-back data (combinational)
//   wbk_en_out    register-file write enable
//   wbk_adr_out   register-file write address
//   split_busy    second beat pending; upstream must stall
//   fwd_data      history data, entry k at [k*XLEN +: XLEN]
//   fwd_adr       history register addresses, entry k at [k*5 +: 5]
//   fwd_vld       history valid bits
//   fsm_state     debug view of the split FSM (0 = IDLE, 1 = WAIT2)
//
// Handshake: a memory beat is accepted in any cycle where ld_vld_wb=1 and
// stall=0. While split_busy=1 the stage waits for the second beat and ignores
// every WB input except ld_data_wb/ld_vld_wb; upstream must hold off.
// ---------------------------------------------------------------------------
module wb_stage_ext #(
    parameter int XLEN      = 32,
    parameter int FWD_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_ld_wb,
    input  logic [2:0]                ld_code_wb,
    input  logic [XLEN-1:0]           rd_data_wb,
    input  logic [XLEN-1:0]           ld_data_wb,
    input  logic                      ld_vld_wb,
    input  logic                      ld_split_wb,
    input  logic                      wbk_en_wb,
    input  logic [4:0]                rd_adr_wb,
    input  logic                      stall,
    input  logic                      rst_pipe,
    output logic [XLEN-1:0]           wbk_data_wb,
    output logic                      wbk_en_out,
    output logic [4:0]                wbk_adr_out,
    output logic                      split_busy,
    output logic [FWD_DEPTH*XLEN-1:0] fwd_data,
    output logic [FWD_DEPTH*5-1:0]    fwd_adr,
    output logic [FWD_DEPTH-1:0]      fwd_vld,
    output logic                      fsm_state
);

    localparam int OFS = $clog2(XLEN/8);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WAIT2 = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Captured first beat and instruction attributes of a split load
    logic [XLEN-1:0] cap_beat1;
    logic [OFS-1:0]  cap_ofs;
    logic [2:0]      cap_code;
    logic [4:0]      cap_adr;
    logic            cap_en;
    logic            capture;
    logic            wb_fire;

    // Size selection and extension of an already right-aligned word.
    // Codes that do not exist for this XLEN produce 0.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] w,
                                               input logic [2:0] code);
        logic [XLEN-1:0] r;
        r = '0;
        case (code)
            3'b000: r = XLEN'($signed(w[7:0]));
            3'b001: r = XLEN'($signed(w[15:0]));
            3'b010: r = XLEN'($signed(w[31:0]));
            3'b011: if (XLEN == 64) r = w;
            3'b100: r = XLEN'(w[7:0]);
            3'b101: r = XLEN'(w[15:0]);
            3'b110: if (XLEN == 64) r = XLEN'(w[31:0]);
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [XLEN-1:0]   aligned;
    logic [2*XLEN-1:0] pair_sh;

    assign aligned = ld_data_wb >> {rd_data_wb[OFS-1:0], 3'b000};
    // Second beat supplies the upper bytes; beat2 arrives on ld_data_wb
    assign pair_sh = {ld_data_wb, cap_beat1} >> {cap_ofs, 3'b000};

    // Next state and outputs
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        wb_fire     = 1'b0;
        wbk_data_wb = rd_data_wb;
        wbk_adr_out = rd_adr_wb;
        case (state)
            IDLE: begin
                if (cmd_ld_wb) begin
                    wbk_data_wb = extend(aligned, ld_code_wb);
                    if (ld_vld_wb && ld_split_wb) begin
                        if (!stall && !rst_pipe) begin
                            capture   = 1'b1;
                            state_nxt = WAIT2;
                        end
                    end else begin
                        wb_fire = ld_vld_wb & wbk_en_wb;
                    end
                end else begin
                    wb_fire = wbk_en_wb;
                end
            end
            WAIT2: begin
                wbk_data_wb = extend(pair_sh[XLEN-1:0], cap_code);
                wbk_adr_out = cap_adr;
                if (rst_pipe) begin
                    state_nxt = IDLE;
                end else if (ld_vld_wb && !stall) begin
                    wb_fire   = cap_en;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wbk_en_out = wb_fire & (wbk_adr_out != 5'd0) & ~stall & ~rst_pipe & rst_n;
    assign split_busy = (state == WAIT2);
    assign fsm_state  = state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture registers; a flush discards a pending first beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_beat1 <= '0;
            cap_ofs   <= '0;
            cap_code  <= '0;
            cap_adr   <= '0;
            cap_en    <= 1'b0;
        end else if (rst_pipe) begin
            cap_beat1 <= '0;
            cap_ofs   <= '0;
            cap_code  <= '0;
            cap_adr   <= '0;
            cap_en    <= 1'b0;
        end else if (capture) begin
            cap_beat1 <= ld_data_wb;
            cap_ofs   <= rd_data_wb[OFS-1:0];
            cap_code  <= ld_code_wb;
            cap_adr   <= rd_adr_wb;
            cap_en    <= wbk_en_wb;
        end
    end

    // Forwarding history: entry 0 is the most recent write-back output
    logic [XLEN-1:0] hist_data [FWD_DEPTH];
    logic [4:0]      hist_adr  [FWD_DEPTH];
    logic            hist_vld  [FWD_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                hist_data[k] <= '0;
                hist_adr[k]  <= '0;
                hist_vld[k]  <= 1'b0;
            end
        end else if (rst_pipe) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                hist_data[k] <= '0;
                hist_adr[k]  <= '0;
                hist_vld[k]  <= 1'b0;
            end
        end else if (!stall) begin
            hist_data[0] <= wbk_data_wb;
            hist_adr[0]  <= wbk_adr_out;
            hist_vld[0]  <= wbk_en_out;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                hist_data[k] <= hist_data[k-1];
                hist_adr[k]  <= hist_adr[k-1];
                hist_vld[k]  <= hist_vld[k-1];
            end
        end
    end

    for (genvar g = 0; g < FWD_DEPTH; g++) begin : g_fwd
        assign fwd_data[g*XLEN +: XLEN] = hist_data[g];
        assign fwd_adr[g*5 +: 5]        = hist_adr[g];
        assign fwd_vld[g]               = hist_vld[g];
    end

endmodule
